// File: rtl/hcsr04_emulator.sv
// HC-SR04 ultrasonic sensor responder.
// Checks the width of each trigger pulse. After an accepted trigger it waits
// for the emulated burst time, then drives an echo pulse whose width encodes
// the programmed distance. A holdoff window follows every echo.
module hcsr04_emulator #(
    parameter int TRIG_MIN_CYCLES = 500,
    parameter int BURST_CYCLES    = 10000,
    parameter int CYCLES_PER_CM   = 2941,
    parameter int TIMEOUT_CYCLES  = 1900000,
    parameter int HOLDOFF_CYCLES  = 3000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       trigger,
    input  logic [8:0] distance_cm,
    input  logic       no_object,
    output logic       echo,
    output logic       busy,
    output logic       trig_error,
    output logic [3:0] db_estado
);

    // The echo width register must hold the larger of the timeout width and
    // the width for the farthest in-range distance, without wrapping.
    localparam int MAX_RANGE_W = 400 * CYCLES_PER_CM;
    localparam int MAX_W = (TIMEOUT_CYCLES > MAX_RANGE_W) ? TIMEOUT_CYCLES : MAX_RANGE_W;
    localparam int W_W   = $clog2(MAX_W + 1);

    // A single counter serves every state, so it must reach the largest
    // terminal count of any of them.
    localparam int MAX_A   = (MAX_W > HOLDOFF_CYCLES) ? MAX_W : HOLDOFF_CYCLES;
    localparam int MAX_B   = (BURST_CYCLES > TRIG_MIN_CYCLES) ? BURST_CYCLES : TRIG_MIN_CYCLES;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] TRIG_MIN   = CNT_W'(TRIG_MIN_CYCLES);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRIG  = 3'd1,
        S_BURST = 3'd2,
        S_ECHO  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] width_last, width_next;
    logic             echo_next;
    logic             trig_error_next;
    logic             ts_meta, ts, ts_prev;
    logic [8:0]       dist_eff;
    logic [W_W-1:0]   w_calc;

    // Bring the raw trigger pin into the clock domain and keep the previous
    // synchronized value so idle only reacts to a genuine rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_meta <= 1'b0;
            ts      <= 1'b0;
            ts_prev <= 1'b0;
        end else begin
            ts_meta <= trigger;
            ts      <= ts_meta;
            ts_prev <= ts;
        end
    end

    // Echo width from the distance inputs; sampled only when a trigger is
    // accepted, so later input changes cannot disturb a measurement.
    always_comb begin
        dist_eff = (distance_cm < 9'd2) ? 9'd2 : distance_cm;
        if (no_object || (distance_cm > 9'd400)) begin
            w_calc = W_W'(TIMEOUT_CYCLES);
        end else begin
            w_calc = W_W'(dist_eff) * W_W'(CYCLES_PER_CM);
        end
    end

    // Next-state logic: trigger qualification, burst wait, echo, holdoff.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        width_next      = width_last;
        echo_next       = 1'b0;
        trig_error_next = 1'b0;
        if (!enable) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            width_next = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_next = '0;
                    if (ts && !ts_prev) begin
                        state_next = S_TRIG;
                        cnt_next   = CNT_ONE;
                    end
                end
                S_TRIG: begin
                    if (ts) begin
                        if (cnt < TRIG_MIN) begin
                            cnt_next = cnt + CNT_ONE;
                        end
                    end else if (cnt >= TRIG_MIN) begin
                        state_next = S_BURST;
                        cnt_next   = '0;
                        width_next = CNT_W'(w_calc) - CNT_ONE;
                    end else begin
                        state_next      = S_IDLE;
                        cnt_next        = '0;
                        trig_error_next = 1'b1;
                    end
                end
                S_BURST: begin
                    if (cnt == BURST_LAST) begin
                        state_next = S_ECHO;
                        cnt_next   = '0;
                        echo_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                S_ECHO: begin
                    if (cnt == width_last) begin
                        state_next = S_HOLD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next  = cnt + CNT_ONE;
                        echo_next = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State, counter and registered pin outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            width_last <= '0;
            echo       <= 1'b0;
            trig_error <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            width_last <= width_next;
            echo       <= echo_next;
            trig_error <= trig_error_next;
        end
    end

    assign busy = (state != S_IDLE);

    // Debug code for the current state; any stray encoding shows as 1110.
    always_comb begin
        case (state)
            S_IDLE:  db_estado = 4'b0000;
            S_TRIG:  db_estado = 4'b0001;
            S_BURST: db_estado = 4'b0010;
            S_ECHO:  db_estado = 4'b0011;
            S_HOLD:  db_estado = 4'b0100;
            default: db_estado = 4'b1110;
        endcase
    end

endmodule

// File: tb/tb_hcsr04_emulator.sv
// Directed bench for hcsr04_emulator using reduced timing parameters.
module tb_hcsr04_emulator;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       trigger = 1'b0;
    logic [8:0] distance_cm = 9'd50;
    logic       no_object = 1'b0;
    logic       echo;
    logic       busy;
    logic       trig_error;
    logic [3:0] db_estado;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    hcsr04_emulator #(
        .TRIG_MIN_CYCLES(10),
        .BURST_CYCLES(20),
        .CYCLES_PER_CM(5),
        .TIMEOUT_CYCLES(3000),
        .HOLDOFF_CYCLES(100)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .trigger(trigger),
        .distance_cm(distance_cm),
        .no_object(no_object),
        .echo(echo),
        .busy(busy),
        .trig_error(trig_error),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Edge index: at a falling edge, cyc is the number of the last rising edge.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive trigger high for n sampling edges; returns N, the first edge sampling 0.
    task automatic applyStimulus(input int n, output int n_edge);
        @(negedge clock);
        trigger = 1'b1;
        repeat (n) @(negedge clock);
        trigger = 1'b0;
        n_edge = cyc + 1;
    endtask

    task automatic pulseTrigger(input int n);
        trigger = 1'b1;
        repeat (n) @(negedge clock);
        trigger = 1'b0;
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic waitEcho(input string tag, input logic lvl, output int at);
        at = -1;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clock);
            if (echo === lvl) begin
                at = cyc;
                break;
            end
        end
        checkOutput($sformatf("%s echo=%0d seen", tag, lvl), int'(at >= 0), 1);
    endtask

    task automatic waitBusyLow(input string tag, output int at);
        at = -1;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clock);
            if (busy === 1'b0) begin
                at = cyc;
                break;
            end
        end
        checkOutput($sformatf("%s busy low seen", tag), int'(at >= 0), 1);
    endtask

    // Follow one measurement from N through echo and holdoff.
    task automatic measure(input string tag, input int n_edge, input int w);
        int rise;
        int fall;
        int drop;
        waitEcho(tag, 1'b1, rise);
        checkOutput($sformatf("%s rise", tag), rise, n_edge + 22);
        checkOutput($sformatf("%s db echo", tag), int'(db_estado), 3);
        waitEcho(tag, 1'b0, fall);
        checkOutput($sformatf("%s width", tag), fall - rise, w);
        checkOutput($sformatf("%s db hold", tag), int'(db_estado), 4);
        waitBusyLow(tag, drop);
        checkOutput($sformatf("%s busy drop", tag), drop, fall + 100);
        checkOutput($sformatf("%s db idle", tag), int'(db_estado), 0);
    endtask

    initial begin
        int n;
        int rise;
        int fall;
        int drop;
        int highs;

        // Reset state
        #2;
        checkOutput("reset echo", int'(echo), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset trig_error", int'(trig_error), 0);
        checkOutput("reset db", int'(db_estado), 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Nominal measurement with state-sequence checks
        $display("[TB] nominal");
        distance_cm = 9'd50;
        trigger = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("nominal busy before", int'(busy), 0);
        @(negedge clock);
        checkOutput("nominal busy trig", int'(busy), 1);
        checkOutput("nominal db trig", int'(db_estado), 1);
        repeat (7) @(negedge clock);
        trigger = 1'b0;
        n = cyc + 1;
        waitCycle(n + 1);
        checkOutput("nominal db N+1", int'(db_estado), 1);
        waitCycle(n + 2);
        checkOutput("nominal db burst", int'(db_estado), 2);
        measure("nominal", n, 250);

        // Short trigger
        $display("[TB] short trigger");
        applyStimulus(9, n);
        waitCycle(n + 1);
        checkOutput("short trig_error N+1", int'(trig_error), 0);
        waitCycle(n + 2);
        checkOutput("short trig_error N+2", int'(trig_error), 1);
        checkOutput("short db N+2", int'(db_estado), 0);
        waitCycle(n + 3);
        checkOutput("short trig_error N+3", int'(trig_error), 0);
        highs = 0;
        repeat (60) begin
            @(negedge clock);
            if (echo === 1'b1 || busy === 1'b1) highs++;
        end
        checkOutput("short no echo", highs, 0);

        // Width boundaries
        $display("[TB] width boundaries");
        distance_cm = 9'd1;
        applyStimulus(10, n);
        measure("dist1", n, 10);
        distance_cm = 9'd2;
        applyStimulus(10, n);
        measure("dist2", n, 10);
        distance_cm = 9'd400;
        applyStimulus(10, n);
        measure("dist400", n, 2000);
        distance_cm = 9'd401;
        applyStimulus(10, n);
        measure("dist401", n, 3000);
        distance_cm = 9'd50;
        no_object = 1'b1;
        applyStimulus(10, n);
        measure("no_object", n, 3000);
        no_object = 1'b0;

        // Retrigger during echo and holdoff
        $display("[TB] retrigger");
        applyStimulus(10, n);
        waitEcho("retrig", 1'b1, rise);
        checkOutput("retrig rise", rise, n + 22);
        pulseTrigger(15);
        waitEcho("retrig", 1'b0, fall);
        checkOutput("retrig width", fall - rise, 250);
        repeat (10) @(negedge clock);
        pulseTrigger(15);
        waitBusyLow("retrig", drop);
        checkOutput("retrig busy drop", drop, fall + 100);
        repeat (40) @(negedge clock);
        checkOutput("retrig stays idle", int'(busy), 0);

        // Trigger held across the end of holdoff
        $display("[TB] held trigger");
        applyStimulus(10, n);
        waitEcho("held", 1'b1, rise);
        waitEcho("held", 1'b0, fall);
        repeat (50) @(negedge clock);
        trigger = 1'b1;
        waitBusyLow("held", drop);
        checkOutput("held busy drop", drop, fall + 100);
        repeat (30) @(negedge clock);
        checkOutput("held not accepted busy", int'(busy), 0);
        checkOutput("held not accepted db", int'(db_estado), 0);
        trigger = 1'b0;
        repeat (5) @(negedge clock);
        applyStimulus(10, n);
        measure("after_held", n, 250);

        // Distance change after latch
        $display("[TB] latching");
        distance_cm = 9'd50;
        applyStimulus(10, n);
        waitCycle(n + 7);
        distance_cm = 9'd10;
        measure("latch", n, 250);
        distance_cm = 9'd50;

        // Asynchronous reset in the middle of an echo
        $display("[TB] reset abort");
        applyStimulus(10, n);
        waitEcho("abort", 1'b1, rise);
        repeat (20) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort echo", int'(echo), 0);
        checkOutput("abort db", int'(db_estado), 0);
        checkOutput("abort busy", int'(busy), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Enable dropped during burst
        $display("[TB] enable abort");
        applyStimulus(10, n);
        waitCycle(n + 8);
        checkOutput("enable db burst", int'(db_estado), 2);
        enable = 1'b0;
        @(negedge clock);
        checkOutput("enable db idle", int'(db_estado), 0);
        checkOutput("enable echo", int'(echo), 0);
        checkOutput("enable busy", int'(busy), 0);
        repeat (30) @(negedge clock);
        checkOutput("enable stays quiet", int'(echo), 0);
        enable = 1'b1;
        repeat (3) @(negedge clock);
        distance_cm = 9'd30;
        applyStimulus(10, n);
        measure("after_enable", n, 150);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
